// File: rtl/spect_regfile_pkg.sv
// Shared types and constants for the configuration register file access arbiter.
package spect_regfile_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] numregs);
      return (addr < numregs);
   endfunction

endpackage

// File: rtl/regfile_access_arbiter_rr_arb2.sv
// Two-way arbiter with a last-grant pointer; FIXED_PRI makes port 0 win every contention.
module rr_arb2
   import spect_regfile_pkg::*;
#(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] i_req,
   input  logic       i_take,
   output logic       o_gnt_valid,
   output port_id_t   o_gnt_id
);

   port_id_t r_last;

   // Last-grant pointer; resetting to port 1 makes port 0 the first contention winner
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= PORT1;
      end else if (i_take && o_gnt_valid) begin
         r_last <= o_gnt_id;
      end
   end

   // Grant decode
   always_comb begin
      o_gnt_valid = |i_req;
      o_gnt_id    = PORT0;
      case (i_req)
         2'b01:   o_gnt_id = PORT0;
         2'b10:   o_gnt_id = PORT1;
         2'b11: begin
            if (FIXED_PRI) begin
               o_gnt_id = PORT0;
            end else begin
               o_gnt_id = ~r_last;
            end
         end
         default: o_gnt_id = PORT0;
      endcase
   end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares the register file's single write/read port between the serial command decoder (port 0)
// and the test/auto-config sequencer (port 1); one-cycle ack per transaction, err on bad address.
module regfile_access_arbiter
   import spect_regfile_pkg::*;
#(
   parameter int NUMREGS   = 9,
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic              rf_write,
   output logic              rf_read,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [ADDR_W-1:0] rf_read_addr,
   input  logic [DATA_W-1:0] rf_read_data
);

   localparam logic [ADDR_W-1:0] NUMREGS_C = ADDR_W'(NUMREGS);

   state_t            r_state;
   state_t            w_next;
   port_id_t          r_port;
   logic              r_we;
   logic              r_err;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DATA_W-1:0] r_rdata;

   logic              w_gnt_valid;
   port_id_t          w_gnt_id;
   logic              w_take;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_in_range;

   assign w_take      = (r_state == ST_IDLE);
   assign w_sel_we    = (w_gnt_id == PORT1) ? p1_we    : p0_we;
   assign w_sel_addr  = (w_gnt_id == PORT1) ? p1_addr  : p0_addr;
   assign w_sel_wdata = (w_gnt_id == PORT1) ? p1_wdata : p0_wdata;
   assign w_in_range  = addr_ok(w_sel_addr, NUMREGS_C);

   rr_arb2 #(
      .FIXED_PRI (FIXED_PRI)
   ) u_arb (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_req       ({p1_req, p0_req}),
      .i_take      (w_take),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode; out-of-range grants skip the regfile and go straight to DONE
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               if (w_in_range) begin
                  w_next = ST_ISSUE;
               end else begin
                  w_next = ST_DONE;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (r_we) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: w_next = ST_DONE;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Latch the granted request; regfile address/data registers only move for in-range accesses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_port    <= PORT0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
         r_wr_addr <= {ADDR_W{1'b0}};
         r_wr_data <= {DATA_W{1'b0}};
         r_rd_addr <= {ADDR_W{1'b0}};
      end else if (w_take && w_gnt_valid) begin
         r_port <= w_gnt_id;
         r_we   <= w_sel_we;
         r_err  <= ~w_in_range;
         if (w_in_range && w_sel_we) begin
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_wdata;
         end
         if (w_in_range && !w_sel_we) begin
            r_rd_addr <= w_sel_addr;
         end
      end
   end

   // Read data capture, held until the next successful read
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata <= {DATA_W{1'b0}};
      end else if (r_state == ST_CAPTURE) begin
         r_rdata <= rf_read_data;
      end
   end

   // Output decode from state and latched flops only
   always_comb begin
      busy          = (r_state != ST_IDLE);
      rf_write      = (r_state == ST_ISSUE) &&  r_we;
      rf_read       = (r_state == ST_ISSUE) && !r_we;
      p0_ack        = (r_state == ST_DONE) && (r_port == PORT0);
      p1_ack        = (r_state == ST_DONE) && (r_port == PORT1);
      err           = (r_state == ST_DONE) && r_err;
      rf_write_addr = r_wr_addr;
      rf_write_data = r_wr_data;
      rf_read_addr  = r_rd_addr;
      rdata         = r_rdata;
   end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench: two arbiter instances (round-robin and fixed-priority) in front of a simple regfile.
module tb_regfile_access_arbiter;

   logic       clk;
   logic       reset_n;
   logic       rf_clr;
   logic       p0_req, p0_we, p1_req, p1_we;
   logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

   logic       p0_ack, p1_ack, err, busy, rf_write, rf_read;
   logic [7:0] rdata, rf_write_addr, rf_write_data, rf_read_addr, rf_rd;

   logic       d1_p0_ack, d1_p1_ack, d1_err, d1_busy, d1_rf_write, d1_rf_read;
   logic [7:0] d1_rdata, d1_rf_write_addr, d1_rf_write_data, d1_rf_read_addr;

   logic       sel_dut;
   logic       mon_p0_ack, mon_p1_ack;
   logic [7:0] mem [0:255];

   int n_total;
   int n_bad;

   regfile_access_arbiter #(.NUMREGS(9), .FIXED_PRI(1'b0)) dut (
      .clk(clk), .reset_n(reset_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
      .rdata(rdata), .err(err), .busy(busy), .rf_write(rf_write), .rf_read(rf_read),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_read_addr(rf_read_addr), .rf_read_data(rf_rd)
   );

   regfile_access_arbiter #(.NUMREGS(9), .FIXED_PRI(1'b1)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(d1_p0_ack),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(d1_p1_ack),
      .rdata(d1_rdata), .err(d1_err), .busy(d1_busy), .rf_write(d1_rf_write), .rf_read(d1_rf_read),
      .rf_write_addr(d1_rf_write_addr), .rf_write_data(d1_rf_write_data),
      .rf_read_addr(d1_rf_read_addr), .rf_read_data(8'h00)
   );

   assign mon_p0_ack = sel_dut ? d1_p0_ack : p0_ack;
   assign mon_p1_ack = sel_dut ? d1_p1_ack : p1_ack;

   // Regfile model for the round-robin instance: registered read, cleared once at start
   always_ff @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         rf_rd <= 8'h00;
      end else begin
         if (rf_write) mem[rf_write_addr] <= rf_write_data;
         if (rf_read) rf_rd <= mem[rf_read_addr];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for an ack on the monitored instance; port=-1 on timeout
   task automatic wait_ack(output int port, output int cycles);
      port   = -1;
      cycles = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (mon_p0_ack || mon_p1_ack) begin
            port   = (mon_p0_ack && mon_p1_ack) ? 2 : (mon_p0_ack ? 0 : 1);
            cycles = i;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int port;
      int cyc;
      int g;
      n_total  = 0;
      n_bad    = 0;
      sel_dut  = 1'b0;
      reset_n  = 1'b0;
      rf_clr   = 1'b1;
      p0_req   = 1'b0; p0_we = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
      p1_req   = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
      repeat (3) tick();
      rf_clr  = 1'b0;
      reset_n = 1'b1;
      tick();

      chk("reset_outs", 64'({busy, p0_ack, p1_ack, err, rf_write, rf_read, rdata,
                             rf_write_addr, rf_write_data, rf_read_addr}), 64'd0);

      // Port 0 write addr 3 = A5
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'd3; p0_wdata = 8'hA5;
      chk("wr_pre_strobe", 64'(rf_write), 64'd0);
      tick();
      chk("wr_strobe", 64'({rf_write, rf_read, busy, p0_ack}), 64'b1010);
      chk("wr_addr_data", 64'({rf_write_addr, rf_write_data}), 64'h03A5);
      p0_wdata = 8'hFF;
      tick();
      chk("wr_ack", 64'({p0_ack, p1_ack, err, rf_write}), 64'b1000);
      p0_req = 1'b0;
      tick();
      chk("wr_idle", 64'({busy, p0_ack}), 64'd0);
      chk("wr_mem", 64'(mem[3]), 64'hA5);

      // Port 0 read addr 3
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'd3;
      tick();
      chk("rd_strobe", 64'({rf_read, rf_write}), 64'b10);
      chk("rd_addr", 64'(rf_read_addr), 64'd3);
      p0_addr = 8'd7;
      tick();
      chk("rd_capture", 64'({rf_read, p0_ack}), 64'd0);
      tick();
      chk("rd_ack", 64'({p0_ack, p1_ack, err}), 64'b100);
      chk("rd_data", 64'(rdata), 64'hA5);
      p0_req = 1'b0;
      tick();

      // Port 1 write to addr 9 = NUMREGS
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'd9; p1_wdata = 8'h3C;
      tick();
      chk("err_ack", 64'({p1_ack, p0_ack, err, rf_write, rf_read}), 64'b10100);
      chk("err_rdata", 64'(rdata), 64'hA5);
      p1_req = 1'b0;
      tick();
      chk("err_clear", 64'({err, p1_ack, busy}), 64'd0);
      chk("err_mem", 64'(mem[9]), 64'h00);

      // Round-robin contention, 4 rounds: grants alternate 0,1,0,1,...
      g = 0;
      for (int r = 0; r < 4; r++) begin
         p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'd0; p0_wdata = 8'(r);
         p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'd1; p1_wdata = 8'(8'h10 + r);
         for (int k = 0; k < 2; k++) begin
            wait_ack(port, cyc);
            chk("rr_grant", 64'(port), 64'(g % 2));
            chk("rr_latency", 64'(cyc), (k == 0) ? 64'd2 : 64'd3);
            if (port != 1) p0_req = 1'b0;
            if (port != 0) p1_req = 1'b0;
            g++;
         end
         tick();
      end
      chk("rr_mem", 64'({mem[0], mem[1]}), 64'h0313);

      // Fixed priority: both held high, port 0 re-issues continuously
      pulse_reset();
      sel_dut = 1'b1;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'd5; p0_wdata = 8'h55;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'd6; p1_wdata = 8'h66;
      for (int k = 0; k < 4; k++) begin
         wait_ack(port, cyc);
         chk("fp_grant", 64'(port), 64'd0);
         chk("fp_latency", 64'(cyc), (k == 0) ? 64'd2 : 64'd3);
      end
      p0_req = 1'b0;
      wait_ack(port, cyc);
      chk("fp_p1_after", 64'(port), 64'd1);
      chk("fp_p1_latency", 64'(cyc), 64'd3);
      p1_req = 1'b0;
      tick();
      chk("fp_idle_outs", 64'({d1_busy, d1_err, d1_rf_write, d1_rf_read, d1_rdata,
                               d1_rf_write_addr, d1_rf_write_data, d1_rf_read_addr}),
          64'({4'b0000, 8'h00, 8'h06, 8'h66, 8'h00}));
      sel_dut = 1'b0;

      // Reset asserted during ISSUE of a write aborts it
      pulse_reset();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'd4; p0_wdata = 8'h5A;
      tick();
      chk("rst_in_issue", 64'({rf_write, busy}), 64'b11);
      reset_n = 1'b0;
      #1;
      chk("rst_outs", 64'({busy, p0_ack, p1_ack, err, rf_write, rf_read, rdata,
                           rf_write_addr, rf_write_data, rf_read_addr}), 64'd0);
      p0_req = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_noack", 64'({p0_ack, p1_ack, busy, rf_write}), 64'd0);
      end
      chk("rst_mem", 64'(mem[4]), 64'h00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
